// File: rtl/sprite_compositor.sv
// Sprite compositing stage between the player FSM and the VGA driver.
// The player position, state and facing are snapshotted once per frame.
// Stage 1 issues a texel address and ROM select.
// Stage 2 waits out the one-cycle ROM read.
// Stage 3 converts RGB565 to RRRGGGBB with colour-key transparency.
// Latency from pixel coordinate to colour is exactly 3 clocks.
module sprite_compositor #(
   parameter int             SCREEN_W       = 640,
   parameter int             SCREEN_H       = 480,
   parameter int             SPRITE_W       = 100,
   parameter int             SPRITE_H       = 100,
   parameter int             ADDR_W         = 14,
   parameter logic [7:0]     BG_COLOR       = 8'h00,
   parameter logic [15:0]    KEY_COLOR      = 16'hF81F,
   parameter logic [7:0]     FALLBACK_COLOR = 8'hFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   input  logic              pixel_valid,
   input  logic [9:0]        posx,
   input  logic [9:0]        posy,
   input  logic [3:0]        state,
   input  logic              facing_left,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [2:0]        rom_sel,
   input  logic [15:0]       rom_data,
   output logic [7:0]        color_out,
   output logic              color_valid
);

   localparam logic [9:0]        LAST_X  = 10'(SCREEN_W - 1);
   localparam logic [9:0]        LAST_Y  = 10'(SCREEN_H - 1);
   localparam logic [10:0]       SW11    = 11'(SPRITE_W);
   localparam logic [10:0]       SH11    = 11'(SPRITE_H);
   localparam logic [ADDR_W-1:0] SW_A    = ADDR_W'(SPRITE_W);
   localparam logic [2:0]        SEL_NONE = 3'd7;

   // Map the player FSM state onto the sprite ROM bank select.
   function automatic logic [2:0] sel_of_state(input logic [3:0] st);
      case (st)
         4'd0:       sel_of_state = 3'd0;
         4'd1, 4'd2: sel_of_state = 3'd1;
         4'd3:       sel_of_state = 3'd2;
         4'd4:       sel_of_state = 3'd3;
         4'd5:       sel_of_state = 3'd4;
         default:    sel_of_state = SEL_NONE;
      endcase
   endfunction

   // Truncate RGB565 to RRRGGGBB by keeping the top bits of each channel.
   function automatic logic [7:0] rgb565_to_332(input logic [15:0] c);
      rgb565_to_332 = {c[15:13], c[10:8], c[4:3]};
   endfunction

   // Frame snapshot registers
   logic [9:0] shx_q, shy_q;
   logic [3:0] shst_q;
   logic       shfl_q;
   logic       snap;

   assign snap = pixel_valid && (pixel_x == LAST_X) && (pixel_y == LAST_Y);

   // Load the player snapshot on the last active pixel so the next frame cannot tear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shx_q  <= '0;
         shy_q  <= '0;
         shst_q <= '0;
         shfl_q <= 1'b0;
      end else if (snap) begin
         shx_q  <= posx;
         shy_q  <= posy;
         shst_q <= state;
         shfl_q <= facing_left;
      end
   end

   // ---- stage 1: hit test and texel address ----
   logic [10:0]       px11, py11, sx11, sy11, lx_raw, lx, ly;
   logic              inside_d;
   logic [ADDR_W-1:0] addr_d;
   logic [2:0]        sel_d;

   // Hit test and address generation in 11 bits so sx+SPRITE_W never wraps.
   always_comb begin
      px11     = {1'b0, pixel_x};
      py11     = {1'b0, pixel_y};
      sx11     = {1'b0, shx_q};
      sy11     = {1'b0, shy_q};
      inside_d = pixel_valid &&
                 (px11 >= sx11) && (px11 < sx11 + SW11) &&
                 (py11 >= sy11) && (py11 < sy11 + SH11);
      lx_raw   = px11 - sx11;
      ly       = py11 - sy11;
      lx       = shfl_q ? (SW11 - 11'd1 - lx_raw) : lx_raw;
      addr_d   = inside_d ? (ADDR_W'(ly) * SW_A + ADDR_W'(lx)) : '0;
      sel_d    = sel_of_state(shst_q);
   end

   logic vld_p1_q, inside_p1_q;

   // Register the ROM request together with its pixel qualifiers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr    <= '0;
         rom_sel     <= SEL_NONE;
         vld_p1_q    <= 1'b0;
         inside_p1_q <= 1'b0;
      end else begin
         rom_addr    <= addr_d;
         rom_sel     <= sel_d;
         vld_p1_q    <= pixel_valid;
         inside_p1_q <= inside_d;
      end
   end

   // ---- stage 2: align qualifiers with the ROM read latency ----
   logic vld_p2_q, inside_p2_q, unmap_p2_q;

   // Pure delay line matching the one-cycle ROM access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2_q    <= 1'b0;
         inside_p2_q <= 1'b0;
         unmap_p2_q  <= 1'b0;
      end else begin
         vld_p2_q    <= vld_p1_q;
         inside_p2_q <= inside_p1_q;
         unmap_p2_q  <= (rom_sel == SEL_NONE);
      end
   end

   // ---- stage 3: colour resolve ----
   logic [7:0] color_d;

   // Priority: invalid/outside -> background, unmapped -> fallback, key -> background.
   always_comb begin
      color_d = BG_COLOR;
      if (vld_p2_q && inside_p2_q) begin
         if (unmap_p2_q)
            color_d = FALLBACK_COLOR;
         else if (rom_data == KEY_COLOR)
            color_d = BG_COLOR;
         else
            color_d = rgb565_to_332(rom_data);
      end
   end

   // Register the final colour and its valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         color_out   <= BG_COLOR;
         color_valid <= 1'b0;
      end else begin
         color_out   <= color_d;
         color_valid <= vld_p2_q;
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a queue-based colour scoreboard.
module tb_sprite_compositor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  pixel_x, pixel_y, posx, posy;
   logic        pixel_valid;
   logic [3:0]  state;
   logic        facing_left;
   logic [13:0] rom_addr;
   logic [2:0]  rom_sel;
   logic [15:0] rom_data;
   logic [7:0]  color_out;
   logic        color_valid;

   always #20 clk = ~clk;

   sprite_compositor dut (
      .clk(clk), .rst_n(rst_n),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
      .posx(posx), .posy(posy), .state(state), .facing_left(facing_left),
      .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_data(rom_data),
      .color_out(color_out), .color_valid(color_valid)
   );

   // Synchronous ROM stand-in: the texel chosen with a pixel appears one cycle after its address.
   logic [15:0] tex_cur = 16'h0000;
   logic [15:0] tex_d1  = 16'h0000;
   always @(posedge clk) begin
      tex_d1   <= tex_cur;
      rom_data <= tex_d1;
   end

   // Expected address/select travel one cycle, like the stage-1 register.
   logic        cur_achk = 1'b0;
   logic [13:0] cur_addr = '0;
   logic [2:0]  cur_sel  = '0;
   logic        a_chk    = 1'b0;
   logic [13:0] a_addr   = '0;
   logic [2:0]  a_sel    = '0;
   always @(posedge clk) begin
      a_chk  <= cur_achk;
      a_addr <= cur_addr;
      a_sel  <= cur_sel;
   end

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (a_chk) begin
               chk("rom_addr", 32'(rom_addr), 32'(a_addr));
               chk("rom_sel", 32'(rom_sel), 32'(a_sel));
            end
            if (color_valid) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pixel: got color %0h required no valid output", color_out);
               end else begin
                  exp = sb.pop_front();
                  chk("color_out", 32'(color_out), 32'(exp));
               end
            end
         end
      end
   endtask

   task automatic drive(input int x, input int y, input logic v, input logic [15:0] tex,
                        input logic achk, input int addr, input int sel,
                        input logic push, input logic [7:0] col);
      @(posedge clk);
      #1;
      pixel_x     = 10'(x);
      pixel_y     = 10'(y);
      pixel_valid = v;
      tex_cur     = tex;
      cur_achk    = achk;
      cur_addr    = 14'(addr);
      cur_sel     = 3'(sel);
      if (push && v) sb.push_back(col);
   endtask

   task automatic px(input int x, input int y, input logic [15:0] tex,
                     input int addr, input int sel, input logic [7:0] col);
      drive(x, y, 1'b1, tex, 1'b1, addr, sel, 1'b1, col);
   endtask

   initial begin
      rst_n = 1'b0; pixel_valid = 1'b0; pixel_x = '0; pixel_y = '0;
      posx = '0; posy = '0; state = '0; facing_left = 1'b0;
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #2;
      chk("reset rom_addr", 32'(rom_addr), 32'd0);
      chk("reset rom_sel", 32'(rom_sel), 32'd7);
      chk("reset color_out", 32'(color_out), 32'h00);
      chk("reset color_valid", 32'(color_valid), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // First frame uses the reset snapshot: sprite at (0,0), idle
      px(10, 20, 16'hA5A5, 2010, 0, 8'hB4);

      // Snapshot sprite at (100,50), idle, facing right
      px(639, 479, 16'h0000, 0, 0, 8'h00);
      posx = 10'd100; posy = 10'd50; state = 4'd0; facing_left = 1'b0;
      px(100, 50,  16'hFFFF, 0,    0, 8'hFF);
      px(199, 149, 16'hF81F, 9999, 0, 8'h00);
      px(200, 50,  16'hFFFF, 0,    0, 8'h00);
      px(99,  50,  16'hFFFF, 0,    0, 8'h00);
      px(150, 60,  16'h07E0, 1050, 0, 8'h1C);
      // Mid-frame position change must not move the sprite yet
      posx = 10'd300;
      px(150, 60,  16'h1234, 1050, 0, 8'h0A);
      px(350, 60,  16'hFFFF, 0,    0, 8'h00);

      // Snapshot sprite at (300,50), state 2, mirrored
      px(639, 479, 16'h0000, 0, 0, 8'h00);
      posx = 10'd300; posy = 10'd50; state = 4'd2; facing_left = 1'b1;
      px(350, 60,  16'hFFFF, 1049, 1, 8'hFF);
      px(150, 60,  16'hFFFF, 0,    1, 8'h00);
      px(300, 50,  16'h07E0, 99,   1, 8'h1C);
      px(305, 51,  16'h1234, 194,  1, 8'h0A);

      // Snapshot unmapped state 9
      px(639, 479, 16'h0000, 0, 1, 8'h00);
      posx = 10'd100; posy = 10'd50; state = 4'd9; facing_left = 1'b0;
      px(100, 50,  16'h1234, 0,    7, 8'hFF);
      px(99,  50,  16'h1234, 0,    7, 8'h00);
      px(150, 60,  16'hF81F, 1050, 7, 8'hFF);
      drive(150, 60, 1'b0, 16'hFFFF, 1'b1, 0, 7, 1'b1, 8'hFF);

      // Snapshot sprite at (600,400), state 5: right edge clips, no wrap
      px(639, 479, 16'h0000, 0, 7, 8'h00);
      posx = 10'd600; posy = 10'd400; state = 4'd5; facing_left = 1'b0;
      px(600, 400, 16'hA5A5, 0,    4, 8'hB4);
      px(639, 410, 16'hFFFF, 1039, 4, 8'hFF);
      px(0,   410, 16'hFFFF, 0,    4, 8'h00);
      // Snapshot pixel lies inside the old sprite and still uses the old values
      px(639, 479, 16'h07E0, 7939, 4, 8'h1C);
      posx = 10'd0; posy = 10'd0; state = 4'd3;
      px(5, 5, 16'hFFFF, 505, 2, 8'hFF);

      // Snapshot sprite at (100,50), state 4, then reset mid-sprite
      px(639, 479, 16'h0000, 0, 2, 8'h00);
      posx = 10'd100; posy = 10'd50; state = 4'd4;
      px(149, 80, 16'hFFFF, 3049, 3, 8'hFF);
      px(150, 80, 16'hFFFF, 3050, 3, 8'hFF);
      drive(151, 80, 1'b1, 16'hFFFF, 1'b0, 0, 0, 1'b0, 8'h00);
      @(posedge clk);
      #1;
      chk("pre-reset color_out", 32'(color_out), 32'hFF);
      chk("pre-reset color_valid", 32'(color_valid), 32'd1);
      rst_n = 1'b0;
      pixel_valid = 1'b0;
      cur_achk = 1'b0;
      #1;
      chk("async reset color_out", 32'(color_out), 32'h00);
      chk("async reset color_valid", 32'(color_valid), 32'd0);
      chk("async reset rom_sel", 32'(rom_sel), 32'd7);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // First valid coordinate after release: reset snapshot (0,0) idle
      px(10, 10, 16'hFFFF, 1010, 0, 8'hFF);
      @(posedge clk);
      #1;
      pixel_valid = 1'b0;
      cur_achk = 1'b0;
      #1 chk("latency cycle1 color_valid", 32'(color_valid), 32'd0);
      @(posedge clk);
      #2 chk("latency cycle2 color_valid", 32'(color_valid), 32'd0);
      @(posedge clk);
      #2 chk("latency cycle3 color_valid", 32'(color_valid), 32'd1);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
